// File: rtl/ravenoc_pkg.sv
// Shared types for the router ingress stage: flit layout, link request
// packing, one-hot route encoding and the XY route helper.
package ravenoc_pkg;

    localparam int COORD_W  = 4;
    localparam int FLIT_W   = 34;
    localparam int REQ_W    = 37;
    localparam int ROUTE_W  = 5;

    // One-hot route bit positions, {L,W,E,S,N} from MSB to LSB
    localparam int ROUTE_N  = 0;
    localparam int ROUTE_S  = 1;
    localparam int ROUTE_E  = 2;
    localparam int ROUTE_W_ = 3;
    localparam int ROUTE_L  = 4;

    typedef logic [FLIT_W-1:0]  flit_t;
    typedef logic [ROUTE_W-1:0] route_t;

    typedef enum logic [1:0] {
        HEAD      = 2'b00,
        BODY      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef struct packed {
        flit_t      flit;
        logic [1:0] vc_id;
        logic       valid;
    } s_flit_req_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } pkt_state_t;

    // XY dimension-order routing: resolve X first, then Y, else local
    function automatic route_t xy_route(input logic [COORD_W-1:0] x_dst,
                                        input logic [COORD_W-1:0] y_dst,
                                        input logic [COORD_W-1:0] x_here,
                                        input logic [COORD_W-1:0] y_here);
        route_t r;
        r = '0;
        if (x_dst > x_here)      r[ROUTE_E]  = 1'b1;
        else if (x_dst < x_here) r[ROUTE_W_] = 1'b1;
        else if (y_dst > y_here) r[ROUTE_N]  = 1'b1;
        else if (y_dst < y_here) r[ROUTE_S]  = 1'b1;
        else                     r[ROUTE_L]  = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO. The caller guarantees push is only
// asserted when there is room (or a pop happens in the same cycle) and pop
// only when not empty; push and pop together leave the count unchanged.
module vc_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since empty gates the output
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/input_module.sv
// Router ingress stage: per-VC flit buffering, XY route computation and a
// per-VC read-side packet tracker that holds the route for body/tail flits.
// Optional macro PKT_ERR_EN adds a write-side packet tracker that drops
// out-of-sequence flits and pulses err_o.
module input_module
    import ravenoc_pkg::*;
#(
    parameter int N_VC       = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int ROUTER_X   = 0,
    parameter int ROUTER_Y   = 0
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [REQ_W-1:0]      fin_req_i,
    output logic [N_VC-1:0]       fin_resp_o,
    output logic [N_VC*REQ_W-1:0] fout_req_o,
    output logic [N_VC*ROUTE_W-1:0] fout_route_o,
    input  logic [N_VC-1:0]       fout_resp_i,
    output logic                  err_o
);

    s_flit_req_t req_in;
    flit_type_t  in_type;
    logic [N_VC-1:0] full;
    logic [N_VC-1:0] empty;
    logic [N_VC-1:0] push;
    logic [N_VC-1:0] pop;
    logic            proto_bad;

    assign req_in  = s_flit_req_t'(fin_req_i);
    assign in_type = flit_type_t'(req_in.flit[33:32]);

`ifdef PKT_ERR_EN
    logic [N_VC-1:0] wr_pkt;
    logic            sel_pkt;
    logic            sel_hit;
    logic            err_q;

    // Protocol check against the addressed VC's write-side packet state
    always_comb begin
        sel_pkt = 1'b0;
        sel_hit = 1'b0;
        for (int v = 0; v < N_VC; v++) begin
            if (int'(req_in.vc_id) == v) begin
                sel_pkt = wr_pkt[v];
                sel_hit = 1'b1;
            end
        end
        if (sel_pkt) proto_bad = req_in.valid && sel_hit && (in_type == HEAD || in_type == HEAD_TAIL);
        else         proto_bad = req_in.valid && sel_hit && (in_type == BODY || in_type == TAIL);
    end

    // Write-side tracker advances only on accepted flits; err_o is a registered pulse
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_pkt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= proto_bad;
            for (int v = 0; v < N_VC; v++) begin
                if (push[v]) begin
                    if (in_type == HEAD)      wr_pkt[v] <= 1'b1;
                    else if (in_type == TAIL) wr_pkt[v] <= 1'b0;
                end
            end
        end
    end

    assign err_o = err_q;
`else
    assign proto_bad = 1'b0;
    assign err_o     = 1'b0;
`endif

    // Write enables: a full FIFO still accepts when it pops in the same cycle
    always_comb begin
        for (int v = 0; v < N_VC; v++) begin
            push[v] = req_in.valid && (int'(req_in.vc_id) == v) && !proto_bad
                      && (!full[v] || pop[v]);
        end
    end

    assign fin_resp_o = ~full;

    for (genvar v = 0; v < N_VC; v++) begin : g_vc
        flit_t      head_flit;
        route_t     route_now;
        route_t     route_q;
        pkt_state_t rd_state;

        vc_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .arst  (arst),
            .push  (push[v]),
            .din   (req_in.flit),
            .pop   (pop[v]),
            .full  (full[v]),
            .empty (empty[v]),
            .dout  (head_flit)
        );

        assign pop[v]    = !empty[v] && fout_resp_i[v];
        assign route_now = xy_route(head_flit[31:28], head_flit[27:24],
                                    COORD_W'(ROUTER_X), COORD_W'(ROUTER_Y));

        // Read-side packet tracker: latch route on head pop, clear on tail pop
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                rd_state <= ST_IDLE;
                route_q  <= '0;
            end else if (pop[v]) begin
                case (flit_type_t'(head_flit[33:32]))
                    HEAD: begin
                        rd_state <= ST_PKT;
                        route_q  <= route_now;
                    end
                    TAIL, HEAD_TAIL: begin
                        rd_state <= ST_IDLE;
                        route_q  <= '0;
                    end
                    default: begin
                        rd_state <= rd_state;
                        route_q  <= route_q;
                    end
                endcase
            end
        end

        assign fout_req_o[v*REQ_W +: REQ_W] = empty[v] ? '0 : {head_flit, 2'(v), 1'b1};
        assign fout_route_o[v*ROUTE_W +: ROUTE_W] =
            empty[v] ? '0 : ((rd_state == ST_PKT) ? route_q : route_now);
    end

endmodule
